// File: rtl/gtx_link_ctrl_pkg.sv
// Shared definitions for the GTX link controller: lane FSM states, comma symbol, counter width.
package gtx_link_ctrl_pkg;

  typedef enum logic [1:0] {
    StWaitRst = 2'd0,
    StTrain   = 2'd1,
    StUp      = 2'd2
  } lane_state_e;

  localparam logic [7:0]  K28_5    = 8'hBC;
  localparam int unsigned CntWidth = 16;

endpackage

// File: rtl/gtx_link_lane.sv
// One GTX lane: userrdy sequencing, comma alignment, link monitoring, TX/RX word handling.
module gtx_link_lane
  import gtx_link_ctrl_pkg::*;
#(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned AlignCnt   = 8,
  parameter int unsigned ErrThresh  = 4,
  parameter int unsigned UserrdyDly = 16,
  localparam int unsigned Bytes     = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 gt_txresetdone_i,
  input  logic                 gt_rxresetdone_i,
  output logic                 gt_txuserrdy_o,
  output logic                 gt_rxuserrdy_o,
  output logic [DataWidth-1:0] gt_txdata_o,
  output logic [Bytes-1:0]     gt_txcharisk_o,
  input  logic [DataWidth-1:0] gt_rxdata_i,
  input  logic [Bytes-1:0]     gt_rxcharisk_i,
  input  logic [Bytes-1:0]     gt_rxdisperr_i,
  input  logic [Bytes-1:0]     gt_rxnotintable_i,
  input  logic [DataWidth-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [DataWidth-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 link_up_o,
  output logic [CntWidth-1:0]  err_count_o,
  input  logic                 clr_err_i
);

  localparam int unsigned DlyW   = (UserrdyDly > 0) ? $clog2(UserrdyDly + 1) : 1;
  localparam int unsigned AlignW = (AlignCnt > 1) ? $clog2(AlignCnt + 1) : 1;
  localparam int unsigned ErrW   = (ErrThresh > 1) ? $clog2(ErrThresh + 1) : 1;

  localparam logic [DlyW-1:0]      DlyMax    = DlyW'(UserrdyDly);
  localparam logic [AlignW-1:0]    AlignLast = AlignW'(AlignCnt - 1);
  localparam logic [ErrW-1:0]      ErrLast   = ErrW'(ErrThresh - 1);
  localparam logic [DataWidth-1:0] CommaWord = DataWidth'(K28_5);
  localparam logic [Bytes-1:0]     CommaK    = Bytes'(1);

  lane_state_e          state_q, state_d;
  logic [DlyW-1:0]      tx_dly_q, tx_dly_d, rx_dly_q, rx_dly_d;
  logic                 tx_rdy_q, tx_rdy_d, rx_rdy_q, rx_rdy_d;
  logic [AlignW-1:0]    align_q, align_d;
  logic [ErrW-1:0]      err_run_q, err_run_d;
  logic [CntWidth-1:0]  err_cnt_q, err_cnt_d;
  logic [DataWidth-1:0] txdata_q, txdata_d, rxdata_q, rxdata_d;
  logic [Bytes-1:0]     txk_q, txk_d;
  logic                 rx_valid_q, rx_valid_d, link_up_q, link_up_d;

  logic rst_done, word_err, clean_comma, data_word;

  assign rst_done    = gt_txresetdone_i & gt_rxresetdone_i;
  assign word_err    = |(gt_rxdisperr_i | gt_rxnotintable_i);
  assign clean_comma = (gt_rxcharisk_i == CommaK) && (gt_rxdata_i[7:0] == K28_5) && !word_err;
  assign data_word   = (gt_rxcharisk_i == '0) && !word_err;

  // Each userrdy follows its own resetdone after a saturating run-length count.
  always_comb begin : p_userrdy
    tx_dly_d = tx_dly_q;
    rx_dly_d = rx_dly_q;
    if (!gt_txresetdone_i) begin
      tx_dly_d = '0;
    end else if (tx_dly_q != DlyMax) begin
      tx_dly_d = tx_dly_q + DlyW'(1);
    end
    if (!gt_rxresetdone_i) begin
      rx_dly_d = '0;
    end else if (rx_dly_q != DlyMax) begin
      rx_dly_d = rx_dly_q + DlyW'(1);
    end
    tx_rdy_d = gt_txresetdone_i && (tx_dly_d == DlyMax);
    rx_rdy_d = gt_rxresetdone_i && (rx_dly_d == DlyMax);
  end

  always_comb begin : p_fsm
    state_d   = state_q;
    align_d   = '0;
    err_run_d = '0;
    unique case (state_q)
      StWaitRst: begin
        if (tx_rdy_q && rx_rdy_q) state_d = StTrain;
      end
      StTrain: begin
        if (clean_comma) begin
          if (align_q == AlignLast) state_d = StUp;
          else                      align_d = align_q + AlignW'(1);
        end
      end
      StUp: begin
        if (word_err) begin
          if (err_run_q == ErrLast) state_d = StTrain;
          else                      err_run_d = err_run_q + ErrW'(1);
        end
      end
      default: state_d = StWaitRst;
    endcase
    // Losing either resetdone overrides everything else.
    if (!rst_done) begin
      state_d   = StWaitRst;
      align_d   = '0;
      err_run_d = '0;
    end
  end

  always_comb begin : p_data
    txdata_d = CommaWord;
    txk_d    = CommaK;
    if ((state_q == StUp) && tx_valid_i) begin
      txdata_d = tx_data_i;
      txk_d    = '0;
    end
    rx_valid_d = (state_q == StUp) && (state_d == StUp) && data_word;
    rxdata_d   = rx_valid_d ? gt_rxdata_i : rxdata_q;
    link_up_d  = (state_d == StUp);
    err_cnt_d  = err_cnt_q;
    if (clr_err_i) begin
      err_cnt_d = '0;
    end else if (word_err && (state_q != StWaitRst) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StWaitRst;
      tx_dly_q   <= '0;
      rx_dly_q   <= '0;
      tx_rdy_q   <= 1'b0;
      rx_rdy_q   <= 1'b0;
      align_q    <= '0;
      err_run_q  <= '0;
      err_cnt_q  <= '0;
      txdata_q   <= CommaWord;
      txk_q      <= CommaK;
      rxdata_q   <= '0;
      rx_valid_q <= 1'b0;
      link_up_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_dly_q   <= tx_dly_d;
      rx_dly_q   <= rx_dly_d;
      tx_rdy_q   <= tx_rdy_d;
      rx_rdy_q   <= rx_rdy_d;
      align_q    <= align_d;
      err_run_q  <= err_run_d;
      err_cnt_q  <= err_cnt_d;
      txdata_q   <= txdata_d;
      txk_q      <= txk_d;
      rxdata_q   <= rxdata_d;
      rx_valid_q <= rx_valid_d;
      link_up_q  <= link_up_d;
    end
  end

  assign gt_txuserrdy_o = tx_rdy_q;
  assign gt_rxuserrdy_o = rx_rdy_q;
  assign gt_txdata_o    = txdata_q;
  assign gt_txcharisk_o = txk_q;
  assign tx_ready_o     = link_up_q;
  assign rx_data_o      = rxdata_q;
  assign rx_valid_o     = rx_valid_q;
  assign link_up_o      = link_up_q;
  assign err_count_o    = err_cnt_q;

endmodule

// File: rtl/gtx_link_ctrl.sv
// Multi-lane GTX link controller: replicates one independent gtx_link_lane per lane.
module gtx_link_ctrl
  import gtx_link_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LANES   = 1,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ALIGN_CNT   = 8,
  parameter int unsigned ERR_THRESH  = 4,
  parameter int unsigned USERRDY_DLY = 16,
  localparam int unsigned BYTES      = DATA_WIDTH / 8
) (
  input  logic                            usrclk_in,
  input  logic                            reset_in,
  input  logic [NUM_LANES-1:0]            gt_txresetdone_in,
  input  logic [NUM_LANES-1:0]            gt_rxresetdone_in,
  output logic [NUM_LANES-1:0]            gt_txuserrdy_out,
  output logic [NUM_LANES-1:0]            gt_rxuserrdy_out,
  output logic [NUM_LANES*DATA_WIDTH-1:0] gt_txdata_out,
  output logic [NUM_LANES*BYTES-1:0]      gt_txcharisk_out,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] gt_rxdata_in,
  input  logic [NUM_LANES*BYTES-1:0]      gt_rxcharisk_in,
  input  logic [NUM_LANES*BYTES-1:0]      gt_rxdisperr_in,
  input  logic [NUM_LANES*BYTES-1:0]      gt_rxnotintable_in,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] tx_data_in,
  input  logic [NUM_LANES-1:0]            tx_valid_in,
  output logic [NUM_LANES-1:0]            tx_ready_out,
  output logic [NUM_LANES*DATA_WIDTH-1:0] rx_data_out,
  output logic [NUM_LANES-1:0]            rx_valid_out,
  output logic [NUM_LANES-1:0]            link_up_out,
  output logic [NUM_LANES*CntWidth-1:0]   err_count_out,
  input  logic                            clr_err_in
);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    gtx_link_lane #(
      .DataWidth  (DATA_WIDTH),
      .AlignCnt   (ALIGN_CNT),
      .ErrThresh  (ERR_THRESH),
      .UserrdyDly (USERRDY_DLY)
    ) u_lane (
      .clk_i             (usrclk_in),
      .rst_i             (reset_in),
      .gt_txresetdone_i  (gt_txresetdone_in[g]),
      .gt_rxresetdone_i  (gt_rxresetdone_in[g]),
      .gt_txuserrdy_o    (gt_txuserrdy_out[g]),
      .gt_rxuserrdy_o    (gt_rxuserrdy_out[g]),
      .gt_txdata_o       (gt_txdata_out[g*DATA_WIDTH +: DATA_WIDTH]),
      .gt_txcharisk_o    (gt_txcharisk_out[g*BYTES +: BYTES]),
      .gt_rxdata_i       (gt_rxdata_in[g*DATA_WIDTH +: DATA_WIDTH]),
      .gt_rxcharisk_i    (gt_rxcharisk_in[g*BYTES +: BYTES]),
      .gt_rxdisperr_i    (gt_rxdisperr_in[g*BYTES +: BYTES]),
      .gt_rxnotintable_i (gt_rxnotintable_in[g*BYTES +: BYTES]),
      .tx_data_i         (tx_data_in[g*DATA_WIDTH +: DATA_WIDTH]),
      .tx_valid_i        (tx_valid_in[g]),
      .tx_ready_o        (tx_ready_out[g]),
      .rx_data_o         (rx_data_out[g*DATA_WIDTH +: DATA_WIDTH]),
      .rx_valid_o        (rx_valid_out[g]),
      .link_up_o         (link_up_out[g]),
      .err_count_o       (err_count_out[g*CntWidth +: CntWidth]),
      .clr_err_i         (clr_err_in)
    );
  end

endmodule

// File: tb/tb_gtx_link_ctrl.sv
// Randomized bench for gtx_link_ctrl: loopback traffic checked every cycle against a lane model.
module tb_gtx_link_ctrl;

  localparam int NL    = 2;
  localparam int DW    = 32;
  localparam int B     = DW / 8;
  localparam int ALIGN = 8;
  localparam int ERRT  = 4;
  localparam int DLY   = 16;
  localparam int MWait = 0, MTrain = 1, MUp = 2;
  localparam logic [DW-1:0] COMMA = 32'h0000_00BC;

  logic             clk = 1'b0;
  logic             rst;
  logic [NL-1:0]    txrd, rxrd, txurdy, rxurdy, tx_valid, tx_ready, rx_valid, link_up;
  logic [NL*DW-1:0] gt_txdata, gt_rxdata, tx_data, rx_data;
  logic [NL*B-1:0]  gt_txk, gt_rxk, gt_rxde, gt_rxnt;
  logic [NL*16-1:0] err_count;
  logic             clr_err;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model of each lane, kept as plain run lengths and a mode number.
  int            m_txrun[NL], m_rxrun[NL], m_mode[NL], m_align[NL], m_errrun[NL], m_errcnt[NL];
  bit            m_txrdy[NL], m_rxrdy[NL], m_up[NL], m_rxv[NL];
  logic [DW-1:0] m_txw[NL], m_rxd[NL];
  logic [B-1:0]  m_txk[NL];

  // Loopback corruption controls.
  bit            inj_err[NL], inj_data[NL], inj_k[NL];
  logic [B-1:0]  inj_de[NL], inj_nt[NL], inj_kv[NL];
  logic [DW-1:0] inj_word[NL];
  int            drop_cnt[NL], drop_sel[NL];

  always #5 clk = ~clk;

  gtx_link_ctrl #(
    .NUM_LANES   (NL),
    .DATA_WIDTH  (DW),
    .ALIGN_CNT   (ALIGN),
    .ERR_THRESH  (ERRT),
    .USERRDY_DLY (DLY)
  ) dut (
    .usrclk_in          (clk),
    .reset_in           (rst),
    .gt_txresetdone_in  (txrd),
    .gt_rxresetdone_in  (rxrd),
    .gt_txuserrdy_out   (txurdy),
    .gt_rxuserrdy_out   (rxurdy),
    .gt_txdata_out      (gt_txdata),
    .gt_txcharisk_out   (gt_txk),
    .gt_rxdata_in       (gt_rxdata),
    .gt_rxcharisk_in    (gt_rxk),
    .gt_rxdisperr_in    (gt_rxde),
    .gt_rxnotintable_in (gt_rxnt),
    .tx_data_in         (tx_data),
    .tx_valid_in        (tx_valid),
    .tx_ready_out       (tx_ready),
    .rx_data_out        (rx_data),
    .rx_valid_out       (rx_valid),
    .link_up_out        (link_up),
    .err_count_out      (err_count),
    .clr_err_in         (clr_err)
  );

  task automatic chk(input string name, input int lane, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d: got 0x%0h want 0x%0h at %0t", name, lane, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      m_txrun[l] = 0;  m_rxrun[l] = 0;  m_txrdy[l] = 0;  m_rxrdy[l] = 0;
      m_mode[l] = MWait; m_align[l] = 0; m_errrun[l] = 0; m_errcnt[l] = 0;
      m_txw[l] = COMMA; m_txk[l] = 4'b0001; m_rxv[l] = 0; m_rxd[l] = '0; m_up[l] = 0;
    end
  endtask

  task automatic model_step();
    for (int l = 0; l < NL; l++) begin
      logic [DW-1:0] w;
      logic [B-1:0]  k;
      bit            err, clean, dok, was_up;
      int            nm;
      w      = gt_rxdata[l*DW +: DW];
      k      = gt_rxk[l*B +: B];
      err    = ((gt_rxde[l*B +: B] | gt_rxnt[l*B +: B]) != '0);
      clean  = (k == 4'b0001) && (w[7:0] == 8'hBC) && !err;
      dok    = (k == '0) && !err;
      was_up = (m_mode[l] == MUp);
      if (was_up && tx_valid[l]) begin
        m_txw[l] = tx_data[l*DW +: DW];
        m_txk[l] = '0;
      end else begin
        m_txw[l] = COMMA;
        m_txk[l] = 4'b0001;
      end
      if (clr_err) m_errcnt[l] = 0;
      else if (err && m_mode[l] != MWait && m_errcnt[l] < 65535) m_errcnt[l]++;
      nm = m_mode[l];
      if (!txrd[l] || !rxrd[l]) begin
        nm = MWait;
      end else if (m_mode[l] == MWait) begin
        if (m_txrdy[l] && m_rxrdy[l]) nm = MTrain;
      end else if (m_mode[l] == MTrain) begin
        m_align[l] = clean ? m_align[l] + 1 : 0;
        if (m_align[l] == ALIGN) nm = MUp;
      end else begin
        m_errrun[l] = err ? m_errrun[l] + 1 : 0;
        if (m_errrun[l] == ERRT) nm = MTrain;
      end
      if (nm != m_mode[l]) begin
        m_align[l]  = 0;
        m_errrun[l] = 0;
      end
      m_rxv[l] = was_up && (nm == MUp) && dok;
      if (m_rxv[l]) m_rxd[l] = w;
      m_up[l]    = (nm == MUp);
      m_txrun[l] = txrd[l] ? m_txrun[l] + 1 : 0;
      m_rxrun[l] = rxrd[l] ? m_rxrun[l] + 1 : 0;
      m_txrdy[l] = (m_txrun[l] >= DLY);
      m_rxrdy[l] = (m_rxrun[l] >= DLY);
      m_mode[l]  = nm;
    end
  endtask

  // RX side sees what the model says the DUT transmits, optionally corrupted.
  task automatic drive_rx();
    for (int l = 0; l < NL; l++) begin
      logic [DW-1:0] w;
      logic [B-1:0]  k, de, nt;
      w = m_txw[l]; k = m_txk[l]; de = '0; nt = '0;
      if (inj_data[l]) begin
        w = inj_word[l];
        k = '0;
      end
      if (inj_k[l]) k = inj_kv[l];
      if (inj_err[l]) begin
        de = inj_de[l];
        nt = inj_nt[l];
      end
      gt_rxdata[l*DW +: DW] = w;
      gt_rxk[l*B +: B]      = k;
      gt_rxde[l*B +: B]     = de;
      gt_rxnt[l*B +: B]     = nt;
    end
  endtask

  task automatic tick();
    drive_rx();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int l = 0; l < NL; l++) begin
        chk("txuserrdy", l, 64'(txurdy[l]), 64'(m_txrdy[l]));
        chk("rxuserrdy", l, 64'(rxurdy[l]), 64'(m_rxrdy[l]));
        chk("gt_txdata", l, 64'(gt_txdata[l*DW +: DW]), 64'(m_txw[l]));
        chk("gt_txcharisk", l, 64'(gt_txk[l*B +: B]), 64'(m_txk[l]));
        chk("tx_ready", l, 64'(tx_ready[l]), 64'(m_up[l]));
        chk("link_up", l, 64'(link_up[l]), 64'(m_up[l]));
        chk("rx_valid", l, 64'(rx_valid[l]), 64'(m_rxv[l]));
        chk("rx_data", l, 64'(rx_data[l*DW +: DW]), 64'(m_rxd[l]));
        chk("err_count", l, 64'(err_count[l*16 +: 16]), 64'(m_errcnt[l]));
      end
    end
  end

  initial begin
    rst = 1'b1; txrd = '0; rxrd = '0; tx_valid = '0; tx_data = '0; clr_err = 1'b0;
    gt_rxdata = '0; gt_rxk = '0; gt_rxde = '0; gt_rxnt = '0;
    for (int l = 0; l < NL; l++) begin
      inj_err[l] = 0; inj_data[l] = 0; inj_k[l] = 0; inj_de[l] = '0; inj_nt[l] = '0;
      inj_kv[l] = '0; inj_word[l] = '0; drop_cnt[l] = 0; drop_sel[l] = 0;
    end
    model_reset();
    cmp_en = 1'b1;

    repeat (3) tick();
    chk("reset link_up", 0, 64'(link_up), 64'h0);
    chk("reset gt_txdata", 0, 64'(gt_txdata), 64'h0000_00BC_0000_00BC);
    chk("reset gt_txcharisk", 0, 64'(gt_txk), 64'h11);
    chk("reset userrdy", 0, 64'({txurdy, rxurdy}), 64'h0);
    rst = 1'b0;

    // Userrdy sequencing after resetdone.
    repeat (10) tick();
    txrd = '1; rxrd = '1;
    repeat (15) tick();
    chk("userrdy before delay", 0, 64'({txurdy, rxurdy}), 64'h0);
    tick();
    chk("userrdy after delay", 0, 64'({txurdy, rxurdy}), 64'hF);
    chk("comma while waiting", 0, 64'(gt_txdata[DW-1:0]), 64'h0000_00BC);
    tick();

    // Alignment restart on a data word after five commas.
    repeat (5) tick();
    inj_data[0] = 1; inj_word[0] = 32'h1234_5678;
    tick();
    inj_data[0] = 0;
    repeat (7) tick();
    chk("link_up after 7 commas", 0, 64'(link_up[0]), 64'h0);
    chk("undisturbed lane up", 1, 64'(link_up[1]), 64'h1);
    tick();
    chk("link_up after 8 commas", 0, 64'(link_up[0]), 64'h1);
    chk("tx_ready in UP", 0, 64'(tx_ready[0]), 64'h1);

    // Single data word through loopback.
    tx_data[DW-1:0] = 32'hDEAD_BEEF; tx_valid[0] = 1'b1;
    tick();
    tx_valid[0] = 1'b0;
    chk("tx word", 0, 64'(gt_txdata[DW-1:0]), 64'hDEAD_BEEF);
    chk("tx word charisk", 0, 64'(gt_txk[B-1:0]), 64'h0);
    tick();
    chk("rx_valid", 0, 64'(rx_valid[0]), 64'h1);
    chk("rx word", 0, 64'(rx_data[DW-1:0]), 64'hDEAD_BEEF);
    tick();
    chk("rx_valid drops", 0, 64'(rx_valid[0]), 64'h0);
    chk("rx word held", 0, 64'(rx_data[DW-1:0]), 64'hDEAD_BEEF);

    // Isolated errors keep the link; a burst of ERRT drops it.
    for (int i = 0; i < 3; i++) begin
      inj_err[0] = 1; inj_de[0] = 4'b0001; inj_nt[0] = '0;
      tick();
      inj_err[0] = 0;
      tick();
    end
    chk("isolated err count", 0, 64'(err_count[15:0]), 64'd3);
    chk("link survives isolated", 0, 64'(link_up[0]), 64'h1);
    inj_err[0] = 1;
    repeat (3) tick();
    chk("link before threshold", 0, 64'(link_up[0]), 64'h1);
    tick();
    inj_err[0] = 0;
    chk("link after threshold", 0, 64'(link_up[0]), 64'h0);
    chk("tx_ready after threshold", 0, 64'(tx_ready[0]), 64'h0);
    chk("burst err count", 0, 64'(err_count[15:0]), 64'd7);
    chk("other lane err count", 1, 64'(err_count[31:16]), 64'd0);

    // Randomized loopback traffic with corruption and resetdone drops.
    for (int c = 0; c < 2000; c++) begin
      for (int l = 0; l < NL; l++) begin
        tx_valid[l]         = 1'($urandom_range(0, 1));
        tx_data[l*DW +: DW] = $urandom();
        inj_err[l]  = ($urandom_range(0, 19) == 0);
        inj_de[l]   = B'($urandom());
        inj_nt[l]   = B'($urandom());
        if (inj_de[l] == '0 && inj_nt[l] == '0) inj_de[l] = 4'b0010;
        inj_data[l] = ($urandom_range(0, 29) == 0);
        inj_word[l] = $urandom();
        inj_k[l]    = ($urandom_range(0, 49) == 0);
        inj_kv[l]   = B'($urandom());
        if (drop_cnt[l] == 0 && $urandom_range(0, 299) == 0) begin
          drop_cnt[l] = $urandom_range(1, 20);
          drop_sel[l] = $urandom_range(1, 3);
        end
        if (drop_cnt[l] > 0) begin
          txrd[l] = (drop_sel[l] & 1) == 0;
          rxrd[l] = (drop_sel[l] & 2) == 0;
          drop_cnt[l]--;
        end else begin
          txrd[l] = 1'b1;
          rxrd[l] = 1'b1;
        end
      end
      clr_err = ($urandom_range(0, 99) == 0);
      tick();
    end
    for (int l = 0; l < NL; l++) begin
      inj_err[l] = 0; inj_data[l] = 0; inj_k[l] = 0;
    end
    tx_valid = '0; clr_err = 1'b0; txrd = '1; rxrd = '1;

    // rxresetdone loss in UP.
    for (int i = 0; i < 200 && !m_up[0]; i++) tick();
    chk("lane up before rxresetdone drop", 0, 64'(link_up[0]), 64'h1);
    rxrd[0] = 1'b0;
    tick();
    chk("rxuserrdy after drop", 0, 64'(rxurdy[0]), 64'h0);
    chk("txuserrdy unaffected", 0, 64'(txurdy[0]), 64'h1);
    chk("link_up after drop", 0, 64'(link_up[0]), 64'h0);
    rxrd[0] = 1'b1;

    // Saturation and clear priority.
    repeat (20) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("err count cleared", 0, 64'(err_count[15:0]), 64'd0);
    inj_err[0] = 1; inj_de[0] = 4'b0100; inj_nt[0] = 4'b0001;
    repeat (65540) tick();
    chk("err count saturates", 0, 64'(err_count[15:0]), 64'hFFFF);
    chk("train under errors", 0, 64'(link_up[0]), 64'h0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clear beats increment", 0, 64'(err_count[15:0]), 64'd0);
    tick();
    chk("count resumes", 0, 64'(err_count[15:0]), 64'd1);
    inj_err[0] = 0;

    // Asynchronous reset mid-traffic.
    tx_valid = '1;
    for (int i = 0; i < 30; i++) begin
      tx_data = {$urandom(), $urandom()};
      tick();
    end
    chk("lane1 up before reset", 1, 64'(link_up[1]), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async rst link_up", 0, 64'(link_up), 64'h0);
    chk("async rst tx_ready", 0, 64'(tx_ready), 64'h0);
    chk("async rst rx_valid", 0, 64'(rx_valid), 64'h0);
    chk("async rst userrdy", 0, 64'({txurdy, rxurdy}), 64'h0);
    chk("async rst err_count", 0, 64'(err_count), 64'h0);
    chk("async rst rx_data", 0, 64'(rx_data), 64'h0);
    chk("async rst gt_txdata", 0, 64'(gt_txdata), 64'h0000_00BC_0000_00BC);
    chk("async rst gt_txcharisk", 0, 64'(gt_txk), 64'h11);
    repeat (3) tick();
    tx_valid = '0;
    rst = 1'b0;
    repeat (5) tick();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
